dual_mem_arbiter: RTL and testbench

- Shares the single RAM port between the instruction and data request streams of both cores in the dual-core system.
- Each core's request unit drives read/write enables; this block grants one access at a time, drives the RAM, and returns a one-cycle hit plus load data to the winner.
- Data accesses have priority over instruction fetches. Round-robin between cores within each class.
- Includes a watchdog that flags a RAM access that never completes.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/arb_priority.sv | 40 ++++
 rtl/dual_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_dual_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: RAM handshake state, data word, and the
// arbiter's FSM state and grant record.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic core;
    logic is_data;
    logic is_write;
  } arb_grant_t;

endpackage

// File: rtl/arb_priority.sv
// Combinational request selector: data before instruction, round-robin
// between the two cores inside each class, starting at the rr pointer.
module arb_priority
  import cpu_types_pkg::*;
(
  input  logic [1:0] i_iren,
  input  logic [1:0] i_dren,
  input  logic [1:0] i_dwen,
  input  logic       i_rr,
  output logic       o_valid,
  output arb_grant_t o_grant
);

  logic [1:0] w_dreq;
  logic       w_nrr;

  assign w_dreq = i_dren | i_dwen;
  assign w_nrr  = ~i_rr;

  always_comb begin
    o_valid = 1'b1;
    o_grant = '0;
    if (w_dreq[i_rr]) begin
      o_grant.core     = i_rr;
      o_grant.is_data  = 1'b1;
      o_grant.is_write = i_dwen[i_rr];
    end else if (w_dreq[w_nrr]) begin
      o_grant.core     = w_nrr;
      o_grant.is_data  = 1'b1;
      o_grant.is_write = i_dwen[w_nrr];
    end else if (i_iren[i_rr]) begin
      o_grant.core = i_rr;
    end else if (i_iren[w_nrr]) begin
      o_grant.core = w_nrr;
    end else begin
      o_valid = 1'b0;
    end
  end

endmodule

// File: rtl/dual_mem_arbiter.sv
// Shares one RAM port between the instruction and data streams of two cores.
// Handshake: a request is held until its one-cycle hit; hit/load are valid only together.
module dual_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CORES    = 2,
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [CORES-1:0]      iREN,
  input  logic [CORES-1:0][31:0] iaddr,
  output logic [CORES-1:0]      ihit,
  output logic [CORES-1:0][31:0] iload,
  input  logic [CORES-1:0]      dREN,
  input  logic [CORES-1:0]      dWEN,
  input  logic [CORES-1:0][31:0] daddr,
  input  logic [CORES-1:0][31:0] dstore,
  output logic [CORES-1:0]      dhit,
  output logic [CORES-1:0][31:0] dload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output word_t                 ramaddr,
  output word_t                 ramstore,
  input  word_t                 ramload,
  input  ramstate_t             ramstate,
  output logic                  timeout,
  output arb_state_t            dbg_state
);

  arb_state_t        r_state;
  arb_grant_t        r_grant;
  logic              r_rr;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_timeout;

  logic       w_valid;
  arb_grant_t w_grant;
  logic       w_in_wait;
  logic       w_done;

  arb_priority u_priority (
    .i_iren  (iREN),
    .i_dren  (dREN),
    .i_dwen  (dWEN),
    .i_rr    (r_rr),
    .o_valid (w_valid),
    .o_grant (w_grant)
  );

  assign w_in_wait = (r_state == WAIT);
  assign w_done    = w_in_wait && (ramstate == ACCESS);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr       <= 1'b0;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_grant <= w_grant;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          case (ramstate)
            ACCESS: begin
              r_rr       <= ~r_grant.core;
              r_wait_cnt <= '0;
              r_state    <= IDLE;
            end
            ERROR: begin
              // rr is left alone so the same requester wins the retry
              r_wait_cnt <= '0;
              r_state    <= IDLE;
            end
            default: begin
              if (r_wait_cnt != WAIT_W'(MAX_WAIT))
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
              if (r_wait_cnt == WAIT_W'(MAX_WAIT - 1))
                r_timeout <= 1'b1;
            end
          endcase
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM side follows the winner's live port inputs while the access is open
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (w_in_wait) begin
      ramWEN = r_grant.is_data & r_grant.is_write;
      ramREN = ~(r_grant.is_data & r_grant.is_write);
      if (r_grant.is_data) begin
        ramaddr  = daddr[r_grant.core];
        ramstore = dstore[r_grant.core];
      end else begin
        ramaddr = iaddr[r_grant.core];
      end
    end
  end

  always_comb begin
    ihit  = '0;
    dhit  = '0;
    iload = '0;
    dload = '0;
    if (w_done) begin
      if (r_grant.is_data) begin
        dhit[r_grant.core]  = 1'b1;
        dload[r_grant.core] = ramload;
      end else begin
        ihit[r_grant.core]  = 1'b1;
        iload[r_grant.core] = ramload;
      end
    end
  end

  assign timeout   = r_timeout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dual_mem_arbiter.sv
// Bench for dual_mem_arbiter: priority table on arb_priority, directed
// corner sequences and a short random run against a hit scoreboard.
module tb_dual_mem_arbiter;
  import cpu_types_pkg::*;

  // clock / reset
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  logic [1:0]       iREN, dREN, dWEN, ihit, dhit;
  logic [1:0][31:0] iaddr, iload, daddr, dstore, dload;
  logic             ramREN, ramWEN, timeout;
  logic [31:0]      ramaddr, ramstore, ramload;
  ramstate_t        ramstate;
  arb_state_t       dbg_state;

  dual_mem_arbiter #(.CORES(2), .MAX_WAIT(255), .WAIT_W(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .timeout(timeout), .dbg_state(dbg_state)
  );

  logic [1:0] p_iren, p_dren, p_dwen;
  logic       p_rr, p_valid;
  arb_grant_t p_grant;

  arb_priority u_prio (
    .i_iren(p_iren), .i_dren(p_dren), .i_dwen(p_dwen), .i_rr(p_rr),
    .o_valid(p_valid), .o_grant(p_grant)
  );

  typedef struct {
    logic [1:0] iren;
    logic [1:0] dren;
    logic [1:0] dwen;
    logic       rr;
    logic       exp_valid;
    arb_grant_t exp_grant;
  } vec_t;

  function automatic vec_t mkv(logic [1:0] iren, logic [1:0] dren, logic [1:0] dwen,
                               logic rr, logic v, logic core, logic isd, logic isw);
    vec_t t;
    t.iren = iren; t.dren = dren; t.dwen = dwen; t.rr = rr;
    t.exp_valid = v;
    t.exp_grant.core = core; t.exp_grant.is_data = isd; t.exp_grant.is_write = isw;
    return t;
  endfunction

  // scoreboard: {is_data, core, load}
  localparam int W = 34;
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input logic is_data, input logic core, input logic [31:0] val);
    logic [W-1:0] got, exp;
    got = {is_data, core, val};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL sb_unexpected_hit: got %h expected no hit", got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_errors++;
        $display("FAIL sb_hit: got %h expected %h", got, exp);
      end
    end
  endtask

  always @(negedge CLK) begin
    for (int c = 0; c < 2; c++) begin
      if (ihit[c]) sb_pop(1'b0, c[0], iload[c]);
      else         chk("iload_zero", iload[c], 32'h0);
      if (dhit[c]) sb_pop(1'b1, c[0], dload[c]);
      else         chk("dload_zero", dload[c], 32'h0);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  vec_t vecs[10];
  int   r_core, r_cls, r_nb;
  logic [31:0] r_ld;

  initial begin
    nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;

    // arb_priority table
    vecs[0] = mkv(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[1] = mkv(2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[2] = mkv(2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[3] = mkv(2'b01, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[4] = mkv(2'b00, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[5] = mkv(2'b00, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    vecs[6] = mkv(2'b00, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    vecs[7] = mkv(2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[8] = mkv(2'b01, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    vecs[9] = mkv(2'b10, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      p_iren = vecs[i].iren; p_dren = vecs[i].dren;
      p_dwen = vecs[i].dwen; p_rr = vecs[i].rr;
      #1;
      chk($sformatf("prio_valid_%0d", i), 32'(p_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        chk($sformatf("prio_grant_%0d", i), 32'(p_grant), 32'(vecs[i].exp_grant));
    end

    // reset with instruction requests pending
    iREN = 2'b11; ramstate = ACCESS; ramload = 32'hDEADBEEF;
    iaddr[0] = 32'h100; iaddr[1] = 32'h200;
    tick(); tick();
    chk("rst_ramREN", 32'(ramREN), 32'h0);
    chk("rst_ramWEN", 32'(ramWEN), 32'h0);
    chk("rst_ihit", 32'(ihit), 32'h0);
    chk("rst_dhit", 32'(dhit), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    exp_q.push_back({1'b0, 1'b0, 32'hDEADBEEF});
    exp_q.push_back({1'b0, 1'b1, 32'hDEADBEEF});
    nRST = 1'b1;
    tick();
    chk("rst_first_ren", 32'(ramREN), 32'h1);
    chk("rst_first_addr", ramaddr, 32'h100);
    chk("rst_first_ihit", 32'(ihit), 32'h1);
    tick();
    iREN = 2'b10;
    chk("rst_dead_ihit", 32'(ihit), 32'h0);
    chk("rst_dead_ren", 32'(ramREN), 32'h0);
    tick();
    chk("rst_second_ihit", 32'(ihit), 32'h2);
    chk("rst_second_addr", ramaddr, 32'h200);
    tick();
    iREN = 2'b00;
    tick();

    // data beats instruction
    iREN = 2'b01; dREN = 2'b10; daddr[1] = 32'hA000; ramload = 32'h12345678;
    exp_q.push_back({1'b1, 1'b1, 32'h12345678});
    exp_q.push_back({1'b0, 1'b0, 32'h12345678});
    tick();
    chk("prio_dhit", 32'(dhit), 32'h2);
    chk("prio_ihit_c2", 32'(ihit), 32'h0);
    chk("prio_addr", ramaddr, 32'hA000);
    chk("prio_ren", 32'(ramREN), 32'h1);
    tick();
    dREN = 2'b00;
    chk("prio_c3_hits", 32'({dhit, ihit}), 32'h0);
    tick();
    chk("prio_ihit_c4", 32'(ihit), 32'h1);
    chk("prio_iaddr", ramaddr, 32'h100);
    tick();
    iREN = 2'b00;
    tick();

    // round-robin writes
    apply_reset();
    dWEN = 2'b11; ramstate = ACCESS;
    for (int k = 0; k < 4; k++) begin
      dstore[0] = $urandom; dstore[1] = $urandom; ramload = $urandom;
      exp_q.push_back({1'b1, k[0], ramload});
      tick();
      chk($sformatf("rr_wen_%0d", k), 32'(ramWEN), 32'h1);
      chk($sformatf("rr_ren_%0d", k), 32'(ramREN), 32'h0);
      chk($sformatf("rr_store_%0d", k), ramstore, dstore[k[0]]);
      chk($sformatf("rr_dhit_%0d", k), 32'(dhit), 32'(2'b01 << k[0]));
      tick();
      chk($sformatf("rr_idle_wen_%0d", k), 32'(ramWEN), 32'h0);
    end
    dWEN = 2'b00;
    tick();

    // BUSY stretch
    dREN = 2'b01; daddr[0] = 32'hB000; ramstate = BUSY; ramload = 32'hCAFE0001;
    exp_q.push_back({1'b1, 1'b0, 32'hCAFE0001});
    tick();
    for (int b = 0; b < 5; b++) begin
      chk($sformatf("busy_nohit_%0d", b), 32'(dhit), 32'h0);
      chk($sformatf("busy_ren_%0d", b), 32'(ramREN), 32'h1);
      tick();
    end
    ramstate = ACCESS;
    #1;
    chk("busy_dhit", 32'(dhit), 32'h1);
    tick();
    dREN = 2'b00; ramstate = FREE;
    chk("busy_timeout", 32'(timeout), 32'h0);
    chk("busy_state", 32'(dbg_state), 32'(IDLE));
    tick();

    // ERROR retry: rr points at core 1 and must not move on ERROR
    dREN = 2'b11; daddr[0] = 32'hC000; daddr[1] = 32'hC100;
    ramstate = ERROR; ramload = 32'h0E0E0E0E;
    exp_q.push_back({1'b1, 1'b1, 32'h0E0E0E0E});
    exp_q.push_back({1'b1, 1'b0, 32'h0E0E0E0E});
    tick();
    chk("err_addr", ramaddr, 32'hC100);
    chk("err_nohit", 32'(dhit), 32'h0);
    tick();
    ramstate = ACCESS;
    chk("err_idle", 32'(dbg_state), 32'(IDLE));
    chk("err_idle_hit", 32'(dhit), 32'h0);
    tick();
    chk("err_retry_addr", ramaddr, 32'hC100);
    chk("err_retry_hit", 32'(dhit), 32'h2);
    tick();
    dREN = 2'b01;
    tick();
    chk("err_next_hit", 32'(dhit), 32'h1);
    chk("err_next_addr", ramaddr, 32'hC000);
    tick();
    dREN = 2'b00;
    tick();

    // reset during WAIT discards the access
    dREN = 2'b01; ramstate = BUSY;
    tick();
    chk("rstw_ren", 32'(ramREN), 32'h1);
    nRST = 1'b0;
    tick();
    ramstate = ACCESS;
    #1;
    chk("rstw_ren_drop", 32'(ramREN), 32'h0);
    chk("rstw_nohit", 32'(dhit), 32'h0);
    dREN = 2'b00;
    tick();
    nRST = 1'b1;
    ramstate = FREE;
    tick();

    // watchdog
    iREN = 2'b01; iaddr[0] = 32'h300; ramstate = BUSY; ramload = 32'h5A5A5A5A;
    exp_q.push_back({1'b0, 1'b0, 32'h5A5A5A5A});
    tick();
    repeat (254) tick();
    chk("wd_early", 32'(timeout), 32'h0);
    tick();
    chk("wd_rise", 32'(timeout), 32'h1);
    repeat (10) tick();
    chk("wd_hold", 32'(timeout), 32'h1);
    chk("wd_nohit", 32'(ihit), 32'h0);
    chk("wd_ren", 32'(ramREN), 32'h1);
    ramstate = ACCESS;
    #1;
    chk("wd_hit", 32'(ihit), 32'h1);
    tick();
    iREN = 2'b00; ramstate = FREE;
    chk("wd_sticky", 32'(timeout), 32'h1);
    tick();

    // random single-requester accesses
    for (int k = 0; k < 8; k++) begin
      r_core = $urandom_range(1);
      r_cls  = $urandom_range(2);
      r_nb   = $urandom_range(3);
      r_ld   = $urandom;
      iaddr[r_core] = $urandom; daddr[r_core] = $urandom; dstore[r_core] = $urandom;
      iREN = (r_cls == 0) ? 2'(1 << r_core) : 2'b00;
      dREN = (r_cls == 1) ? 2'(1 << r_core) : 2'b00;
      dWEN = (r_cls == 2) ? 2'(1 << r_core) : 2'b00;
      ramstate = BUSY; ramload = r_ld;
      exp_q.push_back({(r_cls != 0), r_core[0], r_ld});
      tick();
      chk($sformatf("rnd_addr_%0d", k), ramaddr, (r_cls == 0) ? iaddr[r_core] : daddr[r_core]);
      chk($sformatf("rnd_wen_%0d", k), 32'(ramWEN), (r_cls == 2) ? 32'h1 : 32'h0);
      if (r_cls == 2) chk($sformatf("rnd_store_%0d", k), ramstore, dstore[r_core]);
      for (int b = 0; b < r_nb; b++) tick();
      ramstate = ACCESS;
      #1;
      chk($sformatf("rnd_hit_%0d", k), 32'({dhit, ihit}),
          32'((r_cls == 0) ? (1 << r_core) : (4 << r_core)));
      tick();
      iREN = 2'b00; dREN = 2'b00; dWEN = 2'b00; ramstate = FREE;
    end
    tick();

    apply_reset();
    chk("final_timeout_clear", 32'(timeout), 32'h0);
    tick();
    chk("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
